// File: rtl/mu0_reg12_serial_reader.sv
// Serial readback of a parallel register value.
// Captures D on Start, shifts it out one bit per BIT_CYCLES clocks with an
// optional trailing even-parity bit, then pulses Done for one cycle.
module mu0_reg12_serial_reader #(
  parameter int WIDTH      = 12,
  parameter int BIT_CYCLES = 1,
  parameter int MSB_FIRST  = 1,
  parameter int PARITY_EN  = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] D,
  output logic             Sout,
  output logic             Svalid,
  output logic             Sstrobe,
  output logic             Busy,
  output logic             Done
);

  localparam int F = WIDTH + ((PARITY_EN != 0) ? 1 : 0);
  localparam logic [7:0] BC_M1 = 8'(BIT_CYCLES - 1);
  localparam logic [4:0] F_M1  = 5'(F - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]   r_state;
  logic [F-2:0] r_sh;    // bits still to be sent after the one on Sout
  logic [4:0]   r_bit;
  logic [7:0]   r_div;

  logic [WIDTH-1:0] w_ord;
  logic [F-1:0]     w_frame;
  logic             w_par;

  // Put D in transmit order so the frame always leaves from its top bit
  always_comb begin
    w_ord = D;
    if (MSB_FIRST == 0)
      for (int i = 0; i < WIDTH; i++) w_ord[i] = D[WIDTH-1-i];
  end

  assign w_par = ^D;

  generate
    if (PARITY_EN != 0) begin : g_par
      assign w_frame = {w_ord, w_par};
    end else begin : g_nopar
      assign w_frame = w_ord;
    end
  endgenerate

  // Frame sequencer; all outputs are registered alongside the state
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_sh    <= '0;
      r_bit   <= '0;
      r_div   <= '0;
      Sout    <= 1'b0;
      Svalid  <= 1'b0;
      Sstrobe <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_state <= S_SHIFT;
            r_sh    <= w_frame[F-2:0];
            r_bit   <= '0;
            r_div   <= '0;
            Sout    <= w_frame[F-1];
            Svalid  <= 1'b1;
            Sstrobe <= (BC_M1 == 8'd0);
            Busy    <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (r_div == BC_M1) begin
            if (r_bit == F_M1) begin
              // last bit finished: one Done cycle, Busy still high
              r_state <= S_DONE;
              r_bit   <= '0;
              r_div   <= '0;
              Sout    <= 1'b0;
              Svalid  <= 1'b0;
              Sstrobe <= 1'b0;
              Done    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 5'd1;
              r_div   <= '0;
              Sout    <= r_sh[F-2];
              r_sh    <= r_sh << 1;
              Sstrobe <= (BC_M1 == 8'd0);
            end
          end else begin
            r_div   <= r_div + 8'd1;
            // strobe marks the final cycle of the bit period
            Sstrobe <= ((r_div + 8'd1) == BC_M1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          Done    <= 1'b0;
          Busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          Sout    <= 1'b0;
          Svalid  <= 1'b0;
          Sstrobe <= 1'b0;
          Busy    <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
